// File: rtl/aes_key_pkg.sv
// Shared constants, FSM state encoding and byte-level helpers for the AES-128 key schedule.
// Pure declarations: no latency, no backpressure.
package aes_key_pkg;

  localparam int NR    = 10;
  localparam int RK_W  = 128;
  localparam int IDX_W = 4;

  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(NR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Entry 0 sits in the most significant byte, so entry b lives at bit offset 8*(255-b).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round: next round key from the current key and rcon.
// Purely combinational; no latency, no backpressure.
module aes_key_round_step
  import aes_key_pkg::*;
(
  input  logic [RK_W-1:0] key_in,
  input  logic [7:0]      rcon,
  output logic [RK_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t, n0, n1, n2, n3;

  assign w0 = key_in[31:0];
  assign w1 = key_in[63:32];
  assign w2 = key_in[95:64];
  assign w3 = key_in[127:96];

  // RotWord brings byte 1 down to byte 0; rcon lands on the new byte 0.
  assign t  = sub_word({w3[7:0], w3[31:8]}) ^ {24'h0, rcon};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry bank, done 11 edges after accept.
// start is ignored while busy (not queued); bank read port has one cycle of latency and never stalls.
module aes_key_sched_ctrl
  import aes_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RK_W-1:0]  key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  output logic             rk_out_valid,
  output logic [IDX_W-1:0] rk_out_idx,
  output logic [RK_W-1:0]  rk_out,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [RK_W-1:0]  rd_data
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             busy_q, busy_d, done_q, done_d, kv_q, kv_d;
  logic             rk_vld_q, rk_vld_d;
  logic [IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic [RK_W-1:0]  rk_out_q, rk_out_d;
  logic [RK_W-1:0]  bank_q [0:NR];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [RK_W-1:0]  wr_dat, step_key;
  logic             rd_valid_q;
  logic [RK_W-1:0]  rd_data_q;

  // The streamed key register doubles as the current key fed back into the step.
  aes_key_round_step u_step (
    .key_in  (rk_out_q),
    .rcon    (rcon_q),
    .key_out (step_key)
  );

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    rcon_d   = rcon_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    kv_d     = kv_q;
    rk_vld_d = 1'b0;
    rk_idx_d = rk_idx_q;
    rk_out_d = rk_out_q;
    wr_en    = 1'b0;
    wr_idx   = round_q;
    wr_dat   = step_key;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_EXPAND;
          round_d  = 4'd1;
          rcon_d   = 8'h01;
          busy_d   = 1'b1;
          kv_d     = 1'b0;
          rk_vld_d = 1'b1;
          rk_idx_d = '0;
          rk_out_d = key_in;
          wr_en    = 1'b1;
          wr_idx   = '0;
          wr_dat   = key_in;
        end
      end
      ST_EXPAND: begin
        rk_vld_d = 1'b1;
        rk_idx_d = round_q;
        rk_out_d = step_key;
        wr_en    = 1'b1;
        rcon_d   = xtime(rcon_q);
        round_d  = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round_q    <= '0;
      rcon_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      kv_q       <= 1'b0;
      rk_vld_q   <= 1'b0;
      rk_idx_q   <= '0;
      rk_out_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      kv_q       <= kv_d;
      rk_vld_q   <= rk_vld_d;
      rk_idx_q   <= rk_idx_d;
      rk_out_q   <= rk_out_d;
      rd_valid_q <= rd_en;
      // Read samples the bank before this edge's write lands, so a colliding read sees the old entry.
      if (rd_en) rd_data_q <= (rd_idx <= LAST_ROUND) ? bank_q[rd_idx] : '0;
      if (wr_en) bank_q[wr_idx] <= wr_dat;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign keys_valid   = kv_q;
  assign rk_out_valid = rk_vld_q;
  assign rk_out_idx   = rk_idx_q;
  assign rk_out       = rk_out_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;

endmodule
